// File: rtl/data_mem_arbiter.sv
// Arbiter between the CPU load/store port and the debug loader for one single-port data memory.
// It runs one transaction at a time, waits out the read latency and returns a one-cycle ack to the owner.
module data_mem_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              dbg_req,
    input  logic              dbg_wen,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    output logic              mem_en,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [1:0] WAIT_LOAD = 2'(MEM_LAT - 1);

    state_t            state_r, state_s;
    logic [1:0]        wait_cnt_r, wait_cnt_s;
    logic              prio_r, prio_s;
    logic              wen_r, wen_s;

    logic              req_any_s;
    logic              grant_dbg_s;
    logic              sel_wen_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;

    logic              mem_en_s, mem_wen_s, cpu_ack_s, dbg_ack_s, busy_s, owner_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_s, cpu_rdata_s, dbg_rdata_s;

    // Arbitration: prio_r names the requester that wins a tie (0 = CPU)
    always_comb begin
        req_any_s = cpu_req | dbg_req;
        if (cpu_req && dbg_req) begin
            grant_dbg_s = prio_r;
        end else if (dbg_req) begin
            grant_dbg_s = 1'b1;
        end else begin
            grant_dbg_s = 1'b0;
        end
        if (grant_dbg_s) begin
            sel_wen_s   = dbg_wen;
            sel_addr_s  = dbg_addr;
            sel_wdata_s = dbg_wdata;
        end else begin
            sel_wen_s   = cpu_wen;
            sel_addr_s  = cpu_addr;
            sel_wdata_s = cpu_wdata;
        end
    end

    // State register with latched request type and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 2'd0;
            prio_r     <= 1'b0;
            wen_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
            prio_r     <= prio_s;
            wen_r      <= wen_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s    = state_r;
        wait_cnt_s = wait_cnt_r;
        prio_s     = prio_r;
        wen_s      = wen_r;
        case (state_r)
            ST_IDLE: begin
                if (req_any_s) begin
                    state_s = ST_ACCESS;
                    prio_s  = ~grant_dbg_s;
                    wen_s   = sel_wen_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (wen_r) begin
                    state_s = ST_DONE;
                end else begin
                    state_s    = ST_WAIT;
                    wait_cnt_s = WAIT_LOAD;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == 2'd0) begin
                    state_s = ST_DONE;
                end else begin
                    wait_cnt_s = wait_cnt_r - 2'd1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output next values: every output is computed one cycle ahead and registered
    always_comb begin
        mem_en_s    = 1'b0;
        mem_wen_s   = 1'b0;
        mem_addr_s  = mem_addr;
        mem_wdata_s = mem_wdata;
        cpu_ack_s   = 1'b0;
        dbg_ack_s   = 1'b0;
        cpu_rdata_s = cpu_rdata;
        dbg_rdata_s = dbg_rdata;
        owner_s     = owner;
        busy_s      = (state_s != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                if (req_any_s) begin
                    mem_en_s    = 1'b1;
                    mem_wen_s   = sel_wen_s;
                    mem_addr_s  = sel_addr_s;
                    mem_wdata_s = sel_wdata_s;
                    owner_s     = grant_dbg_s;
                end else begin
                    mem_en_s = 1'b0;
                end
            end
            ST_ACCESS: begin
                if (wen_r) begin
                    cpu_ack_s = ~owner;
                    dbg_ack_s = owner;
                end else begin
                    cpu_ack_s = 1'b0;
                end
            end
            ST_WAIT: begin
                // Final wait cycle: read data is valid on mem_rdata now
                if (wait_cnt_r == 2'd0) begin
                    cpu_ack_s = ~owner;
                    dbg_ack_s = owner;
                    if (owner) begin
                        dbg_rdata_s = mem_rdata;
                    end else begin
                        cpu_rdata_s = mem_rdata;
                    end
                end else begin
                    cpu_ack_s = 1'b0;
                end
            end
            ST_DONE: begin
                mem_en_s = 1'b0;
            end
            default: begin
                mem_en_s = 1'b0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_en    <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_ack   <= 1'b0;
            dbg_ack   <= 1'b0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
            owner     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            mem_en    <= mem_en_s;
            mem_wen   <= mem_wen_s;
            mem_addr  <= mem_addr_s;
            mem_wdata <= mem_wdata_s;
            cpu_ack   <= cpu_ack_s;
            dbg_ack   <= dbg_ack_s;
            cpu_rdata <= cpu_rdata_s;
            dbg_rdata <= dbg_rdata_s;
            owner     <= owner_s;
            busy      <= busy_s;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with MEM_LAT=2: cycle table plus hand-written corner sequences.
module tb_data_mem_arbiter;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 32;
    localparam int MEM_LAT = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_wen, dbg_req, dbg_wen;
    logic [ADDR_W-1:0] cpu_addr, dbg_addr;
    logic [DATA_W-1:0] cpu_wdata, dbg_wdata;
    logic [DATA_W-1:0] cpu_rdata, dbg_rdata;
    logic              cpu_ack, dbg_ack;
    logic              mem_en, mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              busy, owner;

    always #5 clk = ~clk;

    data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dbg_req(dbg_req), .dbg_wen(dbg_wen), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    // Memory model: data is present on mem_rdata only in the cycle MEM_LAT after mem_en
    logic [DATA_W-1:0] mem [0:1023];
    logic [DATA_W-1:0] pipe1 = 32'h0;
    logic [DATA_W-1:0] pipe2 = 32'h0;
    logic              hit_aa = 1'b0;
    assign mem_rdata = pipe2;

    always @(posedge clk) begin
        if (mem_en && mem_wen) begin
            mem[mem_addr] <= mem_wdata;
            if (mem_addr == 10'h0AA) hit_aa <= 1'b1;
        end
        if (mem_en && !mem_wen)
            pipe1 <= (mem_addr == 10'h3FF) ? 32'h12345678 : mem[mem_addr];
        else
            pipe1 <= 32'h0;
        pipe2 <= pipe1;
    end

    typedef struct {
        logic        rst;
        logic        creq; logic cwen; logic [9:0] caddr; logic [31:0] cwd;
        logic        dreq; logic dwen; logic [9:0] daddr; logic [31:0] dwd;
        logic        e_en; logic e_wen; logic [9:0] e_addr; logic [31:0] e_wd;
        logic        e_cack; logic e_dack; logic e_busy; logic e_owner;
        logic [31:0] e_crd; logic [31:0] e_drd;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        reset = 1'b1; cpu_req = 1'b0; cpu_wen = 1'b0; cpu_addr = 10'h0; cpu_wdata = 32'h0;
        dbg_req = 1'b0; dbg_wen = 1'b0; dbg_addr = 10'h0; dbg_wdata = 32'h0;

        // reset / CPU write (N+1 mem_en, N+2 ack)
        vecs[0]  = '{1'b1, 1'b0,1'b0,10'h000,32'h0,        1'b0,1'b0,10'h000,32'h0,        1'b0,1'b0,10'h000,32'h0,        1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0};
        vecs[1]  = '{1'b0, 1'b1,1'b1,10'h005,32'hDEADBEEF, 1'b0,1'b0,10'h000,32'h0,        1'b1,1'b1,10'h005,32'hDEADBEEF, 1'b0,1'b0,1'b1,1'b0, 32'h0,32'h0};
        vecs[2]  = '{1'b0, 1'b1,1'b1,10'h005,32'hDEADBEEF, 1'b0,1'b0,10'h000,32'h0,        1'b0,1'b0,10'h005,32'hDEADBEEF, 1'b1,1'b0,1'b1,1'b0, 32'h0,32'h0};
        vecs[3]  = '{1'b0, 1'b1,1'b1,10'h005,32'hDEADBEEF, 1'b0,1'b0,10'h000,32'h0,        1'b0,1'b0,10'h005,32'hDEADBEEF, 1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0};
        vecs[4]  = '{1'b0, 1'b0,1'b0,10'h000,32'h0,        1'b0,1'b0,10'h000,32'h0,        1'b0,1'b0,10'h005,32'hDEADBEEF, 1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0};
        // debug read of 0x3FF, ack at N+4
        vecs[5]  = '{1'b0, 1'b0,1'b0,10'h000,32'h0,        1'b1,1'b0,10'h3FF,32'hAAAA5555, 1'b1,1'b0,10'h3FF,32'hAAAA5555, 1'b0,1'b0,1'b1,1'b1, 32'h0,32'h0};
        vecs[6]  = '{1'b0, 1'b0,1'b0,10'h000,32'h0,        1'b1,1'b0,10'h3FF,32'hAAAA5555, 1'b0,1'b0,10'h3FF,32'hAAAA5555, 1'b0,1'b0,1'b1,1'b1, 32'h0,32'h0};
        vecs[7]  = '{1'b0, 1'b0,1'b0,10'h000,32'h0,        1'b1,1'b0,10'h3FF,32'hAAAA5555, 1'b0,1'b0,10'h3FF,32'hAAAA5555, 1'b0,1'b0,1'b1,1'b1, 32'h0,32'h0};
        vecs[8]  = '{1'b0, 1'b0,1'b0,10'h000,32'h0,        1'b1,1'b0,10'h3FF,32'hAAAA5555, 1'b0,1'b0,10'h3FF,32'hAAAA5555, 1'b0,1'b1,1'b1,1'b1, 32'h0,32'h12345678};
        vecs[9]  = '{1'b0, 1'b0,1'b0,10'h000,32'h0,        1'b1,1'b0,10'h3FF,32'hAAAA5555, 1'b0,1'b0,10'h3FF,32'hAAAA5555, 1'b0,1'b0,1'b0,1'b1, 32'h0,32'h12345678};
        vecs[10] = '{1'b0, 1'b0,1'b0,10'h000,32'h0,        1'b0,1'b0,10'h000,32'h0,        1'b0,1'b0,10'h3FF,32'hAAAA5555, 1'b0,1'b0,1'b0,1'b1, 32'h0,32'h12345678};
        // reset, then simultaneous requests held: CPU, DBG, CPU
        vecs[11] = '{1'b1, 1'b0,1'b0,10'h000,32'h0,        1'b0,1'b0,10'h000,32'h0,        1'b0,1'b0,10'h000,32'h0,        1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0};
        vecs[12] = '{1'b0, 1'b1,1'b1,10'h010,32'h11111111, 1'b1,1'b1,10'h020,32'h22222222, 1'b1,1'b1,10'h010,32'h11111111, 1'b0,1'b0,1'b1,1'b0, 32'h0,32'h0};
        vecs[13] = '{1'b0, 1'b1,1'b1,10'h010,32'h11111111, 1'b1,1'b1,10'h020,32'h22222222, 1'b0,1'b0,10'h010,32'h11111111, 1'b1,1'b0,1'b1,1'b0, 32'h0,32'h0};
        vecs[14] = '{1'b0, 1'b1,1'b1,10'h010,32'h11111111, 1'b1,1'b1,10'h020,32'h22222222, 1'b0,1'b0,10'h010,32'h11111111, 1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0};
        vecs[15] = '{1'b0, 1'b1,1'b1,10'h010,32'h11111111, 1'b1,1'b1,10'h020,32'h22222222, 1'b1,1'b1,10'h020,32'h22222222, 1'b0,1'b0,1'b1,1'b1, 32'h0,32'h0};
        vecs[16] = '{1'b0, 1'b1,1'b1,10'h010,32'h11111111, 1'b1,1'b1,10'h020,32'h22222222, 1'b0,1'b0,10'h020,32'h22222222, 1'b0,1'b1,1'b1,1'b1, 32'h0,32'h0};
        vecs[17] = '{1'b0, 1'b1,1'b1,10'h010,32'h11111111, 1'b1,1'b1,10'h020,32'h22222222, 1'b0,1'b0,10'h020,32'h22222222, 1'b0,1'b0,1'b0,1'b1, 32'h0,32'h0};
        vecs[18] = '{1'b0, 1'b1,1'b1,10'h010,32'h11111111, 1'b1,1'b1,10'h020,32'h22222222, 1'b1,1'b1,10'h010,32'h11111111, 1'b0,1'b0,1'b1,1'b0, 32'h0,32'h0};
        vecs[19] = '{1'b0, 1'b1,1'b1,10'h010,32'h11111111, 1'b1,1'b1,10'h020,32'h22222222, 1'b0,1'b0,10'h010,32'h11111111, 1'b1,1'b0,1'b1,1'b0, 32'h0,32'h0};
        vecs[20] = '{1'b0, 1'b1,1'b1,10'h010,32'h11111111, 1'b1,1'b1,10'h020,32'h22222222, 1'b0,1'b0,10'h010,32'h11111111, 1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0};
        vecs[21] = '{1'b0, 1'b0,1'b0,10'h000,32'h0,        1'b0,1'b0,10'h000,32'h0,        1'b0,1'b0,10'h010,32'h11111111, 1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0};

        for (int i = 0; i < NV; i++) begin
            reset = vecs[i].rst;
            cpu_req = vecs[i].creq; cpu_wen = vecs[i].cwen; cpu_addr = vecs[i].caddr; cpu_wdata = vecs[i].cwd;
            dbg_req = vecs[i].dreq; dbg_wen = vecs[i].dwen; dbg_addr = vecs[i].daddr; dbg_wdata = vecs[i].dwd;
            step();
            chk($sformatf("v%0d mem_en", i),    {31'h0, mem_en},   {31'h0, vecs[i].e_en});
            chk($sformatf("v%0d mem_wen", i),   {31'h0, mem_wen},  {31'h0, vecs[i].e_wen});
            chk($sformatf("v%0d mem_addr", i),  {22'h0, mem_addr}, {22'h0, vecs[i].e_addr});
            chk($sformatf("v%0d mem_wdata", i), mem_wdata,         vecs[i].e_wd);
            chk($sformatf("v%0d cpu_ack", i),   {31'h0, cpu_ack},  {31'h0, vecs[i].e_cack});
            chk($sformatf("v%0d dbg_ack", i),   {31'h0, dbg_ack},  {31'h0, vecs[i].e_dack});
            chk($sformatf("v%0d busy", i),      {31'h0, busy},     {31'h0, vecs[i].e_busy});
            chk($sformatf("v%0d owner", i),     {31'h0, owner},    {31'h0, vecs[i].e_owner});
            chk($sformatf("v%0d cpu_rdata", i), cpu_rdata,         vecs[i].e_crd);
            chk($sformatf("v%0d dbg_rdata", i), dbg_rdata,         vecs[i].e_drd);
        end
        reset = 1'b0;
        cpu_req = 1'b0; dbg_req = 1'b0;

        // Inputs changed and req dropped after grant: latched write still completes
        cpu_req = 1'b1; cpu_wen = 1'b1; cpu_addr = 10'h055; cpu_wdata = 32'hCAFEF00D;
        step();
        chk("latch access mem_en", {31'h0, mem_en}, 32'h1);
        chk("latch access addr", {22'h0, mem_addr}, 32'h055);
        cpu_addr = 10'h0AA; cpu_wdata = 32'h0; cpu_req = 1'b0;
        step();
        chk("latch done cpu_ack", {31'h0, cpu_ack}, 32'h1);
        chk("latch done addr", {22'h0, mem_addr}, 32'h055);
        chk("latch done wdata", mem_wdata, 32'hCAFEF00D);
        step();
        chk("latch idle busy", {31'h0, busy}, 32'h0);
        chk("latch mem[055]", mem[10'h055], 32'hCAFEF00D);
        chk("latch no write 0AA", {31'h0, hit_aa}, 32'h0);

        // Reset during WAIT of a CPU read, then a clean read
        cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 10'h005;
        step();
        chk("rst read access en", {31'h0, mem_en}, 32'h1);
        chk("rst read access wen", {31'h0, mem_wen}, 32'h0);
        step();
        chk("rst wait busy", {31'h0, busy}, 32'h1);
        reset = 1'b1;
        step();
        chk("rst busy", {31'h0, busy}, 32'h0);
        chk("rst mem_en", {31'h0, mem_en}, 32'h0);
        chk("rst cpu_ack", {31'h0, cpu_ack}, 32'h0);
        chk("rst owner", {31'h0, owner}, 32'h0);
        chk("rst cpu_rdata", cpu_rdata, 32'h0);
        chk("rst mem_addr", {22'h0, mem_addr}, 32'h0);
        chk("rst mem_wdata", mem_wdata, 32'h0);
        reset = 1'b0; cpu_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("post-rst no ack %0d", k), {31'h0, cpu_ack}, 32'h0);
        end
        cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 10'h005;
        lat = 0;
        do begin
            step();
            lat++;
        end while (!cpu_ack && lat < 12);
        chk("re-read ack seen", {31'h0, cpu_ack}, 32'h1);
        chk("re-read latency", lat, 2 + MEM_LAT);
        chk("re-read cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("re-read dbg_ack", {31'h0, dbg_ack}, 32'h0);
        cpu_req = 1'b0;
        step();
        chk("re-read ack pulse", {31'h0, cpu_ack}, 32'h0);
        chk("re-read rdata held", cpu_rdata, 32'hDEADBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Sequences and shares the single-port data memory between two requesters: the CPU control/datapath (load/store) and a debug/program-loader port.
- Arbitrates between the two, then drives the memory enable, write-enable, address and write-data for exactly one transaction at a time.
- Handles the memory read latency and returns read data with a one-cycle acknowledge to the owner.
- Sits between the CPU memory-stage signals and the data memory instance.

Parameters:
- ADDR_W, 10, memory word-address width
- DATA_W, 32, data word width
- MEM_LAT, 1, memory read latency in cycles from the mem_en cycle to valid mem_rdata; legal range 1..3

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high reset
- cpu_req  input  1  CPU request; held high until cpu_ack
- cpu_wen  input  1  CPU request type: 1 = write, 0 = read
- cpu_addr  input  ADDR_W  CPU address
- cpu_wdata  input  DATA_W  CPU write data
- cpu_rdata  output  DATA_W  CPU read data; valid while cpu_ack=1, held afterwards
- cpu_ack  output  1  one-cycle completion pulse to the CPU
- dbg_req, dbg_wen, dbg_addr, dbg_wdata  input  1/1/ADDR_W/DATA_W  debug-port equivalents of the CPU inputs
- dbg_rdata  output  DATA_W  debug read data
- dbg_ack  output  1  debug completion pulse
- mem_en  output  1  memory enable
- mem_wen  output  1  memory write enable
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data
- busy  output  1  high whenever state is not IDLE
- owner  output  1  current or last grant: 0 = CPU, 1 = debug

Behaviour:
- Reset (synchronous): state IDLE. All outputs 0, including cpu_rdata, dbg_rdata and owner. Priority pointer favours the CPU.
- All outputs are registered.
- States:
  - IDLE: if any req is high, grant one requester, latch its wen/addr/wdata, set owner, go to ACCESS. Otherwise stay in IDLE.
  - ACCESS (1 cycle): mem_en=1, mem_wen=latched wen, mem_addr/mem_wdata=latched values. Write: go to DONE. Read: go to WAIT.
  - WAIT (MEM_LAT cycles, down-counter): mem_en=0, mem_wen=0. On the final WAIT cycle, capture mem_rdata into the owner's rdata register, then go to DONE.
  - DONE (1 cycle): owner's ack=1, the other ack=0, then go to IDLE.
- mem_en and mem_wen are 0 in every state other than ACCESS. mem_addr and mem_wdata hold their last values.
- Latency, with the request first seen in IDLE at cycle N:
  - write: mem_en at N+1, ack at N+2.
  - read: mem_en at N+1, ack at N+2+MEM_LAT.
- Arbitration:
  - Single request: grant it.
  - Both requests in the same cycle: round-robin. Grant the requester that was not granted last; the first tie after reset goes to the CPU.
  - A continuously asserted request is granted after at most one transaction of the other requester.
- Handshake:
  - Requester deasserts req in the cycle after ack, or keeps it high to issue a new transaction.
  - IDLE re-arbitrates from the req values present in its cycle.
  - Changes to addr/wdata/wen after the grant are ignored, because the values were latched.
  - Dropping req before ack does not abort the transaction; ack still pulses.
- rdata of a requester changes only when that requester's read completes. Writes leave rdata unchanged.
- Reset mid-transaction: next cycle is IDLE with mem_en=0 and no ack. A write already issued in ACCESS may have completed.
- Back-to-back: minimum spacing between mem_en pulses is 3 cycles for writes (ACCESS, DONE, IDLE).

Test Plan:
1. Reset, then cpu_req=1, cpu_wen=1, cpu_addr=0x005, cpu_wdata=0xDEADBEEF -> mem_en=mem_wen=1 with addr 0x005 and data 0xDEADBEEF exactly at N+1, cpu_ack at N+2 for one cycle, dbg_ack stays 0.
2. MEM_LAT=2, memory model returns 0x12345678, dbg read of addr 0x3FF -> mem_en at N+1 with mem_wen=0, dbg_ack at N+4 with dbg_rdata=0x12345678, cpu_rdata unchanged at 0.
3. cpu_req and dbg_req both raised in the same cycle after reset, both held for three transactions -> grant order CPU, DBG, CPU; owner toggles 0, 1, 0; every ack is a one-cycle pulse.
4. CPU write in flight; change cpu_addr to 0x0AA during the ACCESS cycle -> mem_addr keeps the originally latched value, and the write lands at the original address.
5. Assert reset during the WAIT cycle of a CPU read -> next cycle busy=0, mem_en=0, cpu_ack never pulses, all outputs 0; a new cpu_req afterwards completes normally.
